// File: rtl/mux_stream_pkg.sv
// Shared types for the N:1 streaming mux: arbitration FSM states and index-width helper.
package mux_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_nto1.sv
// Round-robin pick: first valid channel after ptr_i with wrap-around; combinational, 0 cycles.
// No backpressure of its own; the caller only samples the grant while idle.
module rr_arbiter_nto1
  import mux_stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              gnt_vld_o,
  output logic [SEL_W-1:0]  gnt_idx_o
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate back to ptr+1 so the nearest valid one wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = SEL_W'((int'(ptr_i) + i) % NUM_CH);
      if (valid_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux_stream_nto1.sv
// N:1 packet-locked stream mux with registered output; 1 cycle arbitration, 1 cycle in->out.
// in_ready of the locked channel follows the output slot (!out_valid || out_ready).
module mux_stream_nto1
  import mux_stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic [DATA_W-1:0]   ch_data [NUM_CH];
  logic [NUM_CH-1:0]   sel_oh, cur_oh;
  logic                man_vld, rr_vld, slot_free, beat_vld, beat_last, accept;
  logic [SEL_W-1:0]    rr_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // An out-of-range sel shifts the bit out entirely, so it can never grant.
  assign sel_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
  assign cur_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch_q;
  assign man_vld   = |(in_valid & sel_oh);
  assign slot_free = !out_valid_q || out_ready;
  assign beat_vld  = |(in_valid & cur_oh);
  assign beat_last = |(in_last & cur_oh);
  assign accept    = (state_q == LOCK) && slot_free && beat_vld;

  rr_arbiter_nto1 #(
    .NUM_CH(NUM_CH)
  ) u_rr_arb (
    .valid_i  (in_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_vld_o(rr_vld),
    .gnt_idx_o(rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mode ? rr_vld : man_vld) begin
          cur_ch_d = mode ? rr_idx : sel;
          busy_d   = 1'b1;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        if (slot_free) begin
          in_ready = cur_oh;
        end
        if (accept) begin
          out_data_d  = ch_data[cur_ch_q];
          out_last_d  = beat_last;
          out_valid_d = 1'b1;
          if (beat_last) begin
            rr_ptr_d = cur_ch_q;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= SEL_W'(NUM_CH - 1);
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign cur_ch    = cur_ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Scoreboard bench for mux_stream_nto1: a 4-channel instance for the main scenarios and a
// 6-channel instance for the out-of-range manual select case.
module tb_mux_stream_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, out_ready, busy, out_valid, out_last;
  logic [1:0]  sel, cur_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;

  logic        mode6, out_ready6, busy6, out_valid6, out_last6;
  logic [2:0]  sel6, cur_ch6;
  logic [47:0] in_data6;
  logic [5:0]  in_valid6, in_last6, in_ready6;
  logic [7:0]  out_data6;

  mux_stream_nto1 #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .cur_ch(cur_ch), .busy(busy)
  );

  mux_stream_nto1 #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
    .in_data(in_data6), .in_valid(in_valid6), .in_last(in_last6), .in_ready(in_ready6),
    .out_data(out_data6), .out_valid(out_valid6), .out_last(out_last6), .out_ready(out_ready6),
    .cur_ch(cur_ch6), .busy(busy6)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       chk;
    logic [1:0] ch;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] chq[4][$];
  logic [7:0] sb6[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int n = sb.size();
    for (int c = 0; c < 4; c++) n += chq[c].size();
    return n;
  endfunction

  task automatic push_pkt(input int ch, input logic [7:0] first, input int n,
                          input logic chk_ch, input logic expect_out);
    for (int i = 0; i < n; i++) begin
      chq[ch].push_back({(i == n - 1), 8'(first + 8'(i))});
      if (expect_out)
        sb.push_back(exp_t'{d: 8'(first + 8'(i)), l: (i == n - 1), chk: chk_ch, ch: 2'(ch)});
    end
  endtask

  task automatic wait_ov(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk(name, out_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, pending(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Producer: presents the head of each channel queue, pops it after a handshake.
  initial begin
    logic [3:0] fired;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    forever begin
      @(negedge clk);
      fired = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (fired[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        if (chq[c].size() > 0) begin
          in_valid[c]       = 1'b1;
          in_data[c*8 +: 8] = chq[c][0][7:0];
          in_last[c]        = chq[c][0][8];
        end else begin
          in_valid[c] = 1'b0;
          in_last[c]  = 1'b0;
        end
      end
    end
  end

  // Monitor for the 4-channel instance.
  initial begin
    logic       stall_q;
    logic [7:0] hold_d;
    logic       hold_l;
    logic [3:0] exp_rdy;
    exp_t       e;
    stall_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
        continue;
      end
      exp_rdy = (busy && (!out_valid || out_ready)) ? (4'b0001 << cur_ch) : 4'b0000;
      chk("in_ready", in_ready, exp_rdy);
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_last", out_last, hold_l);
      end
      stall_q = out_valid && !out_ready;
      hold_d  = out_data;
      hold_l  = out_last;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          if (e.chk) chk("cur_ch", cur_ch, e.ch);
        end
      end
    end
  end

  // Monitor for the 6-channel instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid6 && out_ready6) begin
        if (sb6.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat6: got %0h expected none", out_data6);
        end else begin
          chk("out6_data", out_data6, sb6.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    mode6 = 1'b0; sel6 = '0; out_ready6 = 1'b1;
    in_valid6 = '0; in_last6 = '0; in_data6 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Manual 3-beat packet on ch2 streams back-to-back.
    @(posedge clk); #1 sel = 2'd2;
    push_pkt(2, 8'hA1, 3, 1'b1, 1'b1);
    wait_ov("t1_first");
    @(negedge clk); chk("t1_consec2", out_valid, 1);
    @(negedge clk); chk("t1_consec3", out_valid, 1);
    wait_drain("t1_drain");

    // Backpressure for 3 cycles in the middle of a 5-beat packet.
    @(posedge clk); #1 sel = 2'd0;
    push_pkt(0, 8'hB0, 5, 1'b1, 1'b1);
    wait_ov("t3_start");
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_rdy", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("t3_drain");

    // sel moves 1->3 while ch1 is locked.
    @(posedge clk); #1 sel = 2'd1;
    push_pkt(1, 8'hC1, 4, 1'b1, 1'b1);
    push_pkt(3, 8'hD1, 1, 1'b1, 1'b1);
    wait_ov("t4_start");
    @(posedge clk); #1 sel = 2'd3;
    wait_drain("t4_drain");

    // Reset in the middle of a stalled packet; the partial packet is dropped.
    @(posedge clk); #1 mode = 1'b1; out_ready = 1'b0;
    push_pkt(2, 8'hE0, 4, 1'b0, 1'b0);
    wait_ov("t5_start");
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cur_ch", cur_ch, 0);
    for (int c = 0; c < 4; c++) chq[c].delete();
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;

    // Round-robin: two rounds of single-beat packets on all channels, starting at ch0.
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) push_pkt(c, 8'(8'h10 * (c + 1)), 1, 1'b1, 1'b1);
    wait_drain("t2_round1");
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) push_pkt(c, 8'(8'h10 * (c + 1) + 1), 1, 1'b1, 1'b1);
    wait_drain("t2_round2");

    // Six channels: sel=5 is granted, sel=6 is out of range.
    @(posedge clk); #1;
    sel6 = 3'd5; in_valid6[5] = 1'b1; in_last6[5] = 1'b1; in_data6[40 +: 8] = 8'h55;
    sb6.push_back(8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready6[5] && n < 50);
    chk("t6_ready5", in_ready6[5], 1);
    chk("t6_cur_ch", cur_ch6, 5);
    @(posedge clk); #1 in_valid6 = '0; in_last6 = '0;
    n = 0;
    while (sb6.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_drain", sb6.size(), 0);
    @(posedge clk); #1 sel6 = 3'd6; in_valid6 = '1; in_last6 = '1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_busy", busy6, 0);
      chk("t6_in_ready", in_ready6, 0);
      chk("t6_out_valid", out_valid6, 0);
    end
    @(posedge clk); #1 in_valid6 = '0; in_last6 = '0;

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
